pipe_hazard_tracker: RTL

- Parametrised hazard and forwarding tracker for the pipelined datapath; generalises the fixed 5-stage forwarding/hazard logic to any number of post-decode stages and source operands.
- Tracks in-flight register writes in a shift register of stage entries, detects load-use hazards and asserts stall.
- Produces registered per-operand forwarding selects for the execute stage.
- Also flushes selected stages and keeps a saturating stall counter for performance measurement.

---
 rtl/pipe_hazard_tracker_if.sv | 32 +++
 rtl/pipe_hazard_tracker.sv | 107 ++++++++++
 2 files changed

// File: rtl/pipe_hazard_tracker_if.sv
// Bundle of decode-side issue signals and tracker results for pipe_hazard_tracker.
// The master modport belongs to the decode/control side and the slave modport to the tracker.
interface pipe_hazard_tracker_if #(
  parameter int NSTAGE = 3,
  parameter int NSRC   = 2,
  parameter int RSEL_W = 5,
  parameter int CNT_W  = 16
);
  localparam int FW = $clog2(NSTAGE + 1);

  logic                     advance;
  logic                     issue_valid;
  logic                     issue_wen;
  logic [RSEL_W-1:0]        issue_wsel;
  logic                     issue_is_load;
  logic [NSRC*RSEL_W-1:0]   src_sel;
  logic [NSTAGE-1:0]        flush_mask;
  logic                     stall;
  logic [NSRC*FW-1:0]       fwd_sel;
  logic [NSTAGE-1:0]        stage_valid;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output advance, issue_valid, issue_wen, issue_wsel, issue_is_load, src_sel, flush_mask,
    input  stall, fwd_sel, stage_valid, stall_cnt
  );

  modport slave (
    input  advance, issue_valid, issue_wen, issue_wsel, issue_is_load, src_sel, flush_mask,
    output stall, fwd_sel, stage_valid, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_tracker.sv
// Tracks in-flight register writes across NSTAGE post-decode stages, raises load-use stalls
// and produces registered per-operand forwarding selects aligned with the EX stage.
module pipe_hazard_tracker #(
  parameter int NSTAGE   = 3,
  parameter int NSRC     = 2,
  parameter int RSEL_W   = 5,
  parameter int LOAD_RDY = 2,
  parameter int CNT_W    = 16
) (
  input logic CLK,
  input logic RST,
  pipe_hazard_tracker_if.slave bus
);
  localparam int FW = $clog2(NSTAGE + 1);

  logic [NSTAGE-1:0]  valid_q, valid_d;
  logic [NSTAGE-1:0]  wen_q, wen_d;
  logic [NSTAGE-1:0]  load_q, load_d;
  logic [RSEL_W-1:0]  wsel_q [NSTAGE];
  logic [RSEL_W-1:0]  wsel_d [NSTAGE];
  logic [NSRC*FW-1:0] fwd_q, fwd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NSRC-1:0]    match_hit;
  logic [NSRC-1:0]    hazard;
  logic [FW-1:0]      match_fwd [NSRC];
  logic               stall;
  logic               accept;

  // Scan oldest to youngest so the youngest writer overwrites older matches. A match at stage k
  // will sit at stage k+1 when the consumer reaches EX; beyond the last stage the value is in the
  // register file. A load still in a stage below LOAD_RDY has no data to hand over yet.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      match_hit[i] = 1'b0;
      hazard[i]    = 1'b0;
      match_fwd[i] = '0;
      for (int k = NSTAGE; k >= 1; k--) begin
        if (valid_q[k-1] && wen_q[k-1] && (wsel_q[k-1] != '0) &&
            (wsel_q[k-1] == bus.src_sel[i*RSEL_W +: RSEL_W])) begin
          match_hit[i] = 1'b1;
          hazard[i]    = load_q[k-1] && (k < LOAD_RDY);
          match_fwd[i] = (k + 1 > NSTAGE) ? '0 : FW'(k + 1);
        end
      end
    end
  end

  assign stall  = bus.issue_valid && (|hazard);
  assign accept = bus.issue_valid && bus.advance && !stall;

  // Flush is applied last so it also kills an entry shifted into stage 1 this cycle.
  always_comb begin
    valid_d = valid_q;
    wen_d   = wen_q;
    load_d  = load_q;
    wsel_d  = wsel_q;
    fwd_d   = fwd_q;
    cnt_d   = cnt_q;
    if (bus.advance) begin
      for (int k = NSTAGE - 1; k >= 1; k--) begin
        valid_d[k] = valid_q[k-1];
        wen_d[k]   = wen_q[k-1];
        load_d[k]  = load_q[k-1];
        wsel_d[k]  = wsel_q[k-1];
      end
      valid_d[0] = accept;
      wen_d[0]   = accept && bus.issue_wen;
      load_d[0]  = accept && bus.issue_is_load;
      wsel_d[0]  = accept ? bus.issue_wsel : '0;
      for (int i = 0; i < NSRC; i++) begin
        fwd_d[i*FW +: FW] = (accept && match_hit[i]) ? match_fwd[i] : '0;
      end
      if (stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    valid_d = valid_d & ~bus.flush_mask;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      wen_q   <= '0;
      load_q  <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        wsel_q[k] <= '0;
      end
      fwd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      load_q  <= load_d;
      for (int k = 0; k < NSTAGE; k++) begin
        wsel_q[k] <= wsel_d[k];
      end
      fwd_q   <= fwd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.fwd_sel     = fwd_q;
  assign bus.stage_valid = valid_q;
  assign bus.stall_cnt   = cnt_q;
endmodule
